lmem_stream_reader: RTL
=======================

Name: lmem_stream_reader

Overview:
- Read-side controller for one port of the local-memory (LMEM) true-dual-port block RAM.
- On a start command it sweeps a contiguous address range through the RAM read port (write enable held low).
- Absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream to downstream TyTra compute pipelines.
- Sustains one word per clock when the sink never stalls.

Parameters:
DATA_WIDTH, 18, width of an LMEM word and of the output stream
ADDR_WIDTH, 10, LMEM address width; memory depth is 2**ADDR_WIDTH words

Ports:
clk  in  1  clock; all logic on the rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first address of the sweep
length  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
busy  out  1  high from the accepted start until the done pulse, inclusive
done  out  1  single-cycle pulse after the last word is accepted downstream
mem_addr  out  ADDR_WIDTH  address to the LMEM port
mem_we  out  1  LMEM write enable; constant 0
mem_data  out  DATA_WIDTH  LMEM write data; constant 0
mem_q  in  DATA_WIDTH  LMEM registered read data
out_valid  out  1  stream data valid
out_ready  in  1  stream sink ready
out_data  out  DATA_WIDTH  stream data

Behaviour:
- Reset (asynchronous, rstn=0) forces:
  - all outputs to 0: busy, done, mem_addr, out_valid, out_data
  - state IDLE, in-flight flag cleared, skid buffer emptied, counters 0
- Reset mid-sweep abandons the sweep; no done pulse is produced.
- State IDLE:
  - start=1 latches addr_ptr=base_addr and remaining=length.
  - If length=0: go to DONE. Otherwise go to RUN.
- State RUN: a read is issued in a cycle when both hold:
  - remaining>0
  - (buffer_count + inflight - pop) < 2, where pop = out_valid & out_ready in that cycle
- On issue:
  - mem_addr is driven with addr_ptr.
  - At the clock edge: inflight is set, addr_ptr increments modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 -> 0), remaining decrements.
- Data capture: inflight=1 means mem_q is valid in the current cycle. It is pushed into a 2-entry FIFO skid buffer at that edge.
- Output stream:
  - out_data and out_valid are driven from the head of the skid buffer (registered, no combinational path from mem_q).
  - out_valid=1 whenever the buffer is non-empty.
- Handshake: once out_valid is high, out_valid and out_data hold stable until out_ready=1.
- Simultaneous push and pop is permitted; occupancy is unchanged.
- Buffer can never overflow; overflow is a checked assertion.
- RUN -> DONE when remaining=0, inflight=0, the buffer is empty, and the last word was popped.
- State DONE: done=1 for exactly one cycle, busy=1 in that cycle. Next state is IDLE.
- start while not in IDLE is ignored.
- Timing with start accepted at edge E0:
  - Issue window is cycles 1 onward; mem_addr=base_addr after E0.
  - RAM returns word after E1; word is captured after E2.
  - First out_valid is in cycle 2 after E0 (latency 2 edges).
  - Steady state is 1 word/clock while out_ready=1.
- mem_addr holds its last issued value when not issuing.

Test Plan:
- Preload RAM[i]=i+0x100. start, base_addr=5, length=4, out_ready=1 -> out_data 0x105,0x106,0x107,0x108 on consecutive cycles; first out_valid 2 edges after start; done pulses 1 cycle after the last handshake; busy low the following cycle.
- length=0 -> no out_valid ever; busy and done both high for exactly one cycle, then IDLE.
- base_addr=1022, length=4, ADDR_WIDTH=10 -> mem_addr sequence 1022,1023,0,1; data RAM[1022],RAM[1023],RAM[0],RAM[1].
- length=16 with out_ready toggling pseudo-randomly, including a stall of 5 cycles -> all 16 words delivered in order, none dropped or duplicated; out_data stable while stalled; buffer occupancy never exceeds 2.
- start pulsed again mid-sweep with a different base_addr -> ignored; original sweep completes unchanged.
- rstn asserted low in the middle of the third word of a length=8 sweep -> outputs 0 immediately (asynchronously); no done; a new start after release runs cleanly from its own base_addr.

Source files
------------

// File: rtl/lmem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : lmem_stream_reader
// Brief   : Sweeps an LMEM address range and streams the read words out as a
//           valid/ready stream through a 2-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module lmem_stream_reader #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occ_sum;
    logic [2:0]            occ_limit;

    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        push      = inflight_q;
        // A read may only launch if its word is guaranteed a slot on arrival.
        occ_sum   = {1'b0, count_q} + {2'b00, inflight_q};
        occ_limit = 3'd2 + {2'b00, pop};
        issue     = (state_q == ST_RUN) && (remaining_q != '0) && (occ_sum < occ_limit);

        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        last_addr_d = last_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_ptr_d  = base_addr;
                    remaining_d = length;
                    state_d     = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_ptr_d  = addr_ptr_q + ADDR_ONE;
                    last_addr_d = addr_ptr_q;
                    remaining_d = remaining_q - REM_ONE;
                end
                if ((remaining_q == '0) && !inflight_q && (count_q == 2'd1) && pop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_d = count_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = mem_q;
                end else begin
                    buf1_d = mem_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = mem_q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = mem_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_ptr_q  <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            last_addr_q <= last_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Address is shown combinationally only while issuing, otherwise it holds.
    assign mem_addr  = issue ? addr_ptr_q : last_addr_q;
    assign mem_we    = 1'b0;
    assign mem_data  = '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf0_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && (count_q == 2'd2)));

endmodule
`default_nettype wire
